// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the alu_operand_loader stage: FSM state encoding
// and default widths, common to the other projectALU stages.
package alu_operand_loader_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 8;

    // 2'b11 is unused; the loader steers it back to LOAD_A.
    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        PRESENT = 2'b10
    } state_e;

endpackage

// File: rtl/alu_operand_loader_par_chk.sv
// Odd-parity checker for one 8-bit beat: ok is high when {par, data}
// contains an odd number of ones.
module par_chk8 (
    input  logic [7:0] data,
    input  logic       par,
    output logic       ok
);

    // Reduction XOR over the whole beat; odd population yields 1.
    assign ok = ^{par, data};

endmodule

// File: rtl/alu_operand_loader.sv
// Operand loader in front of the ALU 2:1 operand mux.
// Collects A then B from a shared bus, samples the select with B, and holds
// the set stable until the downstream handshake retires it. Counts retired
// sets in a wrapping counter.
// Optional feature: define ALU_OPLOAD_PARITY_EN to add odd-parity checking
// of input beats (in_par input, sticky par_err output).
module alu_operand_loader
    import alu_operand_loader_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_s,
    output logic             op_valid,
    input  logic             op_ready,
`ifdef ALU_OPLOAD_PARITY_EN
    input  logic             in_par,
    output logic             par_err,
`endif
    output logic [CNT_W-1:0] xfer_cnt
);

    state_e             state_q,    state_d;
    logic [WIDTH-1:0]   op_a_q,     op_a_d;
    logic [WIDTH-1:0]   op_b_q,     op_b_d;
    logic               op_s_q,     op_s_d;
    logic               op_valid_q, op_valid_d;
    logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
    logic               par_ok;
    logic               beat_accept;

`ifdef ALU_OPLOAD_PARITY_EN
    logic               par_err_q,  par_err_d;

    // Parity of the beat currently on the bus (checker is 8 bits wide).
    par_chk8 u_par_chk (
        .data (in_data),
        .par  (in_par),
        .ok   (par_ok)
    );
`else
    assign par_ok = 1'b1;
`endif

    // Ready depends only on the loading phase; a bad-parity beat keeps it high.
    assign in_ready    = ~rst & ((state_q == LOAD_A) | (state_q == LOAD_B));
    assign beat_accept = in_valid & in_ready & par_ok;

    // Next-state and datapath update for the load/present sequence.
    always_comb begin
        // NOTE: every variable gets a hold value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_s_d     = op_s_q;
        op_valid_d = op_valid_q;
        xfer_cnt_d = xfer_cnt_q;

        case (state_q)
            LOAD_A: begin
                if (beat_accept) begin
                    op_a_d  = in_data;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (beat_accept) begin
                    op_b_d     = in_data;
                    op_s_d     = in_sel;
                    op_valid_d = 1'b1;
                    state_d    = PRESENT;
                end
            end
            PRESENT: begin
                if (op_ready) begin
                    op_valid_d = 1'b0;
                    xfer_cnt_d = xfer_cnt_q + 1'b1;
                    state_d    = LOAD_A;
                end
            end
            default: begin
                // Unused encoding: restart collection, never present a set.
                op_valid_d = 1'b0;
                state_d    = LOAD_A;
            end
        endcase
    end

`ifdef ALU_OPLOAD_PARITY_EN
    // Sticky parity error: set by any offered beat that fails the check.
    always_comb begin
        par_err_d = par_err_q | (in_valid & in_ready & ~par_ok);
    end
`endif

    // State and operand registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // computed before this edge, independent of statement order.
        if (rst) begin
            state_q    <= LOAD_A;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_s_q     <= 1'b0;
            op_valid_q <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_s_q     <= op_s_d;
            op_valid_q <= op_valid_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

`ifdef ALU_OPLOAD_PARITY_EN
    // Parity error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`endif

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_s     = op_s_q;
    assign op_valid = op_valid_q;
    assign xfer_cnt = xfer_cnt_q;

endmodule
